// File: rtl/field_key_encoder.sv
// Pops object_buffer entries and streams each protobuf key ((field_id<<3)|wire_type) as varint bytes,
// with the entry's descriptor presented alongside for the payload mover.
`default_nettype none

package field_key_encoder_pkg;
  localparam int OFF_W = 32;
  localparam int SIZE_W = 32;
  localparam int TBL_W = 16;

  typedef struct packed {
    logic [31:0]       field_id;
    logic [4:0]        field_type;
    logic              nested;
    logic [OFF_W-1:0]  offset;
    logic [SIZE_W-1:0] size;
    logic [TBL_W-1:0]  nested_type_table;
  } table_entry_t;
endpackage

module field_key_encoder
  import field_key_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  table_entry_t      ob_entry,
  input  logic              ob_valid,
  output logic              ob_pop,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [OFF_W-1:0]  desc_offset,
  output logic [SIZE_W-1:0] desc_size,
  output logic              desc_nested,
  output logic [TBL_W-1:0]  desc_table,
  output logic              err_type,
  output logic [CNT_W-1:0]  key_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       key_q, key_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        idx_q, idx_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              nest_q, nest_d;
  logic [TBL_W-1:0]  tbl_q, tbl_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]  wire_type;
  logic        type_ok;
  logic        drop;
  logic [31:0] new_key;
  logic [2:0]  new_nbytes;
  logic        is_last_idx;
  logic        hs;
  logic        done;
  logic [6:0]  group;

  always_comb begin
    wire_type = 3'd0;
    type_ok   = 1'b1;
    case (ob_entry.field_type)
      5'd1, 5'd6, 5'd16:  wire_type = 3'd1;
      5'd2, 5'd7, 5'd15:  wire_type = 3'd5;
      5'd9, 5'd11, 5'd12: wire_type = 3'd2;
      5'd10:              wire_type = 3'd3;
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: wire_type = 3'd0;
      default:            type_ok = 1'b0;
    endcase
    if (ob_entry.nested) begin
      wire_type = 3'd2;
      type_ok   = 1'b1;
    end
    drop    = !type_ok || (|ob_entry.field_id[31:29]) || (ob_entry.field_id == 32'd0);
    new_key = {ob_entry.field_id[28:0], wire_type};
    if (new_key < 32'h0000_0080)      new_nbytes = 3'd1;
    else if (new_key < 32'h0000_4000) new_nbytes = 3'd2;
    else if (new_key < 32'h0020_0000) new_nbytes = 3'd3;
    else if (new_key < 32'h1000_0000) new_nbytes = 3'd4;
    else                              new_nbytes = 3'd5;
  end

  always_comb begin
    case (idx_q)
      3'd0:    group = key_q[6:0];
      3'd1:    group = key_q[13:7];
      3'd2:    group = key_q[20:14];
      3'd3:    group = key_q[27:21];
      default: group = {3'b000, key_q[31:28]};
    endcase
  end

  assign is_last_idx = (idx_q == nbytes_q - 3'd1);
  assign out_valid   = (state_q == EMIT);
  assign out_last    = out_valid && is_last_idx;
  assign out_data    = {!is_last_idx, group};
  assign hs          = out_valid && out_ready;
  assign done        = hs && out_last;
  assign ob_pop      = ob_valid && ((state_q == IDLE) || done);

  assign desc_offset = off_q;
  assign desc_size   = size_q;
  assign desc_nested = nest_q;
  assign desc_table  = tbl_q;
  assign err_type    = err_q;
  assign key_count   = cnt_q;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    nbytes_d = nbytes_q;
    idx_d    = idx_q;
    off_d    = off_q;
    size_d   = size_q;
    nest_d   = nest_q;
    tbl_d    = tbl_q;
    err_d    = 1'b0;
    cnt_d    = done ? cnt_q + 1'b1 : cnt_q;
    if (done) begin
      state_d = IDLE;
      idx_d   = 3'd0;
    end else if (hs) begin
      idx_d = idx_q + 3'd1;
    end
    // A pop on the final handshake overrides the return to IDLE, giving bubble-free back-to-back keys.
    if (ob_pop) begin
      if (drop) begin
        err_d = 1'b1;
      end else begin
        state_d  = EMIT;
        key_d    = new_key;
        nbytes_d = new_nbytes;
        idx_d    = 3'd0;
        off_d    = ob_entry.offset;
        size_d   = ob_entry.size;
        nest_d   = ob_entry.nested;
        tbl_d    = ob_entry.nested_type_table;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      key_q    <= '0;
      nbytes_q <= 3'd1;
      idx_q    <= 3'd0;
      off_q    <= '0;
      size_q   <= '0;
      nest_q   <= 1'b0;
      tbl_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      nbytes_q <= nbytes_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      nest_q   <= nest_d;
      tbl_q    <= tbl_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire
